// File: rtl/ds_pad_arbiter.sv
// Round-robin arbiter that lets two requesters share one differential tristate pad.
// Each grant drives for a bounded burst, and the pad is left undriven for a fixed turnaround between owners.
module ds_pad_arbiter #(
  parameter int TURN_CYCLES = 2,
  parameter int MAX_BURST   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       din0,
  input  logic       din1,
  output logic [1:0] grant,
  output logic       oe,
  output logic       o_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [7:0] MAX_BEATS  = 8'(MAX_BURST);
  localparam logic [3:0] TURN_LAST  = 4'(TURN_CYCLES);

  state_t     state, state_next;
  logic [1:0] grant_next;
  logic       oe_next, data_next;
  logic       ptr, ptr_next;
  logic [7:0] beat_cnt, beat_next;
  logic [3:0] turn_cnt, turn_next;

  logic [1:0] din_vec;
  logic       pick;
  logic       owner;
  logic       enter_drive;

  assign din_vec = {din1, din0};
  assign owner   = grant[1];
  // A lone requester wins outright; on a tie the requester that did not own last wins.
  assign pick    = (req == 2'b10) || ((req == 2'b11) && !ptr);
  assign busy    = (state != IDLE);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_next  = state;
    grant_next  = 2'b00;
    oe_next     = 1'b0;
    data_next   = 1'b0;
    ptr_next    = ptr;
    beat_next   = beat_cnt;
    turn_next   = turn_cnt;
    enter_drive = 1'b0;

    case (state)
      IDLE: begin
        if (req != 2'b00) enter_drive = 1'b1;
      end
      DRIVE: begin
        if (!req[owner] || (beat_cnt == MAX_BEATS)) begin
          state_next = TURN;
          turn_next  = 4'd1;
          beat_next  = 8'd0;
        end else begin
          beat_next  = beat_cnt + 8'd1;
          grant_next = grant;
          oe_next    = 1'b1;
          data_next  = din_vec[owner];
        end
      end
      TURN: begin
        // The turnaround always runs to completion; requests are only looked at on its last cycle.
        if (turn_cnt == TURN_LAST) begin
          turn_next = 4'd0;
          if (req != 2'b00) enter_drive = 1'b1;
          else              state_next  = IDLE;
        end else begin
          turn_next = turn_cnt + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = 8'd0;
        turn_next  = 4'd0;
      end
    endcase

    if (enter_drive) begin
      state_next = DRIVE;
      grant_next = pick ? 2'b10 : 2'b01;
      oe_next    = 1'b1;
      data_next  = din_vec[pick];
      ptr_next   = pick;
      beat_next  = 8'd1;
      turn_next  = 4'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 2'b00;
      oe       <= 1'b0;
      o_data   <= 1'b0;
      ptr      <= 1'b1;
      beat_cnt <= 8'd0;
      turn_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      oe       <= oe_next;
      o_data   <= data_next;
      ptr      <= ptr_next;
      beat_cnt <= beat_next;
      turn_cnt <= turn_next;
    end
  end

endmodule

// File: tb/tb_ds_pad_arbiter.sv
// Drives two arbiter instances (default and MAX_BURST=4/TURN_CYCLES=3) from the same stimulus.
// Both are compared every cycle against an owner/gap-countdown model of the arbitration rules.
module tb_ds_pad_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic       din0 = 1'b0;
  logic       din1 = 1'b0;

  logic [1:0] grant_o [2];
  logic       oe_o    [2];
  logic       data_o  [2];
  logic       busy_o  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ds_pad_arbiter #(.TURN_CYCLES(2), .MAX_BURST(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .din0(din0), .din1(din1),
    .grant(grant_o[0]), .oe(oe_o[0]), .o_data(data_o[0]), .busy(busy_o[0])
  );

  ds_pad_arbiter #(.TURN_CYCLES(3), .MAX_BURST(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .din0(din0), .din1(din1),
    .grant(grant_o[1]), .oe(oe_o[1]), .o_data(data_o[1]), .busy(busy_o[1])
  );

  // owner: -1 when nobody drives; gap: turnaround cycles still to go.
  typedef struct {
    int owner;
    int beats;
    int gap;
    int last;
    bit data;
  } model_t;

  model_t m [2];
  int     run [2];
  int     low [2];
  bit     seen [2];

  function automatic int max_burst(int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic int turn_cycles(int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic model_t step(model_t s, bit rs, logic [1:0] r, logic [1:0] d, int mb, int tc);
    model_t n;
    bit     start;
    int     w;
    n     = s;
    start = 1'b0;
    if (!rs) begin
      n.owner = -1; n.beats = 0; n.gap = 0; n.last = 1; n.data = 1'b0;
      return n;
    end
    if (s.owner >= 0) begin
      if (!r[s.owner] || s.beats == mb) begin
        n.owner = -1; n.gap = tc; n.data = 1'b0;
      end else begin
        n.beats = s.beats + 1;
        n.data  = d[s.owner];
      end
    end else if (s.gap > 1) begin
      n.gap = s.gap - 1;
    end else begin
      n.gap = 0;
      start = (r != 2'b00);
    end
    if (start) begin
      if (r == 2'b01)      w = 0;
      else if (r == 2'b10) w = 1;
      else                 w = (s.last == 0) ? 1 : 0;
      n.owner = w; n.last = w; n.beats = 1; n.data = d[w];
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic [1:0] eg;
      eg = (m[i].owner < 0) ? 2'b00 : (m[i].owner == 0 ? 2'b01 : 2'b10);
      check($sformatf("grant%0d", i), 32'(grant_o[i]), 32'(eg));
      check($sformatf("oe%0d", i), 32'(oe_o[i]), 32'(m[i].owner >= 0));
      check($sformatf("o_data%0d", i), 32'(data_o[i]), 32'((m[i].owner >= 0) && m[i].data));
      check($sformatf("busy%0d", i), 32'(busy_o[i]), 32'((m[i].owner >= 0) || (m[i].gap > 0)));
      check($sformatf("oe_eq_grant%0d", i), 32'(oe_o[i]), 32'(|grant_o[i]));
      if (!rst_n) begin
        run[i] = 0; low[i] = 0; seen[i] = 1'b0;
      end else if (oe_o[i]) begin
        if (run[i] == 0 && seen[i])
          check($sformatf("turn_gap%0d", i), 32'(low[i] >= turn_cycles(i)), 32'd1);
        run[i]++;
        low[i]  = 0;
        seen[i] = 1'b1;
        check($sformatf("burst_len%0d", i), 32'(run[i] <= max_burst(i)), 32'd1);
      end else begin
        run[i] = 0;
        low[i]++;
      end
    end
  endtask

  // Inputs change on the falling edge; the model steps on the rising edge; outputs are checked on the next falling edge.
  task automatic tick(input logic [1:0] r, input logic [1:0] d, input bit rs);
    req   = r;
    din0  = d[0];
    din1  = d[1];
    rst_n = rs;
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      m[i] = step(m[i], rs, r, d, max_burst(i), turn_cycles(i));
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [1:0] r;
    logic [1:0] dv;
    for (int i = 0; i < 2; i++) begin
      m[i] = '{owner: -1, beats: 0, gap: 0, last: 1, data: 1'b0};
      run[i] = 0; low[i] = 0; seen[i] = 1'b0;
    end
    @(negedge clk);

    // Reset state, then both requesting from release: requester 0 gets the first tie.
    tick(2'b00, 2'b00, 1'b0);
    tick(2'b00, 2'b00, 1'b0);
    for (int k = 0; k < 44; k++) tick(2'b11, 2'(k), 1'b1);
    tick(2'b00, 2'b00, 1'b1);
    for (int k = 0; k < 6; k++) tick(2'b00, 2'b00, 1'b1);

    // Short burst from requester 0 with din0 = 1,0,1.
    tick(2'b01, 2'b01, 1'b1);
    tick(2'b01, 2'b00, 1'b1);
    tick(2'b01, 2'b01, 1'b1);
    for (int k = 0; k < 6; k++) tick(2'b00, 2'b00, 1'b1);

    // Requester 1 alone and held: repeated bursts separated by turnarounds.
    for (int k = 0; k < 26; k++) tick(2'b10, 2'(k * 3), 1'b1);

    // Requester 1 releases, requester 0 appears during the turnaround.
    for (int k = 0; k < 6; k++) tick(2'b00, 2'b00, 1'b1);
    for (int k = 0; k < 3; k++) tick(2'b10, 2'b10, 1'b1);
    tick(2'b00, 2'b00, 1'b1);
    for (int k = 0; k < 6; k++) tick(2'b01, 2'b01, 1'b1);
    tick(2'b00, 2'b00, 1'b1);
    for (int k = 0; k < 5; k++) tick(2'b00, 2'b00, 1'b1);

    // Reset during the fifth drive cycle, then a tie after release.
    for (int k = 0; k < 5; k++) tick(2'b11, 2'b11, 1'b1);
    tick(2'b11, 2'b11, 1'b0);
    for (int k = 0; k < 12; k++) tick(2'b11, 2'b01, 1'b1);

    // Random traffic: requests tend to hold for several cycles, with occasional resets.
    r = 2'b00;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 3) == 0) r = 2'($urandom_range(0, 3));
      dv = 2'($urandom_range(0, 3));
      tick(r, dv, $urandom_range(0, 299) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
